// File: rtl/adc_cmd_arbiter_if.sv
// adc_cmd_arbiter_if
//   Bundles the requester-side and ADC-side signals of adc_cmd_arbiter.
//
//   Handshake semantics, used identically on every channel below:
//     a transfer happens on a rising CLK edge where the producer's valid
//     and the consumer's ready are both high. A producer holds valid and
//     its payload (channel, SOP/EOP) stable until that edge. Strobes
//     without a ready partner (rsp_valid, rsp_err, ADC_R_Valid) are
//     single-cycle and are consumed unconditionally.
//
//   Ports (per modport):
//     slave  - the arbiter: consumes req_*/ADC_R_*/ADC_C_Ready and
//              produces req_ready, rsp_*, ADC_C_*.
//     master - the environment (requesters + ADC): the mirror image.
interface adc_cmd_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [5*N_REQ-1:0] req_channel;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_err;
    logic [11:0]        rsp_data;

    logic               ADC_C_Valid;
    logic               ADC_C_SOP;
    logic               ADC_C_EOP;
    logic [4:0]         ADC_C_Channel;
    logic               ADC_C_Ready;

    logic               ADC_R_Valid;
    logic               ADC_R_SOP;
    logic               ADC_R_EOP;
    logic [4:0]         ADC_R_Channel;
    logic [11:0]        ADC_R_Data;

    modport slave (
        input  req_valid, req_channel, ADC_C_Ready,
        input  ADC_R_Valid, ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data,
        output req_ready, rsp_valid, rsp_err, rsp_data,
        output ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel
    );

    modport master (
        output req_valid, req_channel, ADC_C_Ready,
        output ADC_R_Valid, ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data,
        input  req_ready, rsp_valid, rsp_err, rsp_data,
        input  ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel
    );
endinterface

// File: rtl/adc_cmd_arbiter.sv
// adc_cmd_arbiter
//   Round-robin arbiter granting N_REQ requesters access to a single ADC.
//   One conversion is outstanding at a time: IDLE picks a winner, CMD
//   issues a single-beat command, WAIT looks for the response on the
//   latched channel (with a timeout), RESP returns the result or error.
//
//   Ports:
//     CLK       - system clock, rising edge
//     RESETn    - asynchronous active-low reset
//     bus       - adc_cmd_arbiter_if.slave (requests, responses, ADC streams)
//     busy      - high whenever the FSM is not IDLE
//     owner     - index of the current or last granted requester
//     state_dbg - raw FSM state for observation
module adc_cmd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    adc_cmd_arbiter_if.slave        bus,
    output logic                    busy,
    output logic [2:0]              owner,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);

    state_t             state, state_n;
    logic [2:0]         last_grant;
    logic [2:0]         owner_q;
    logic [4:0]         chan_q;
    logic [11:0]        data_q;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;

    logic               any_req;
    logic               above_found;
    logic [2:0]         lo_idx;
    logic [2:0]         hi_idx;
    logic [2:0]         winner;
    logic [4:0]         win_chan;
    logic               rsp_match;
    logic [N_REQ-1:0]   owner_oh;
    logic               unused_rsp_framing;

    // Round robin: the lowest requesting index above last_grant wins;
    // if none is above, wrap to the lowest requesting index overall.
    // The descending loop leaves the lowest matching index in each slot.
    always_comb begin
        any_req     = 1'b0;
        above_found = 1'b0;
        lo_idx      = '0;
        hi_idx      = '0;
        win_chan    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any_req = 1'b1;
                lo_idx  = 3'(i);
                if (3'(i) > last_grant) begin
                    above_found = 1'b1;
                    hi_idx      = 3'(i);
                end
            end
        end
        winner = above_found ? hi_idx : lo_idx;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == winner) begin
                win_chan = bus.req_channel[5*i +: 5];
            end
        end
    end

    assign rsp_match = bus.ADC_R_Valid && (bus.ADC_R_Channel == chan_q);

    // Next-state logic. In WAIT a matching response is checked before the
    // timeout so that a response on the last counted cycle still wins.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req)         state_n = CMD;
            CMD:     if (bus.ADC_C_Ready) state_n = WAIT;
            WAIT:    if (rsp_match || (cnt == CNT_LAST)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            last_grant <= 3'(N_REQ - 1);
            owner_q    <= '0;
            chan_q     <= '0;
            data_q     <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= winner;
                        last_grant <= winner;
                        chan_q     <= win_chan;
                    end
                end
                CMD: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (rsp_match) begin
                        data_q <= bus.ADC_R_Data;
                        err_q  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign owner_oh = ONE << owner_q;

    // req_ready is combinational so the accept strobe lands in the same
    // IDLE cycle as selection; gating with RESETn keeps it low in reset.
    assign bus.req_ready     = (state == IDLE && any_req && RESETn) ? (ONE << winner) : '0;
    assign bus.rsp_valid     = (state == RESP && !err_q) ? owner_oh : '0;
    assign bus.rsp_err       = (state == RESP &&  err_q) ? owner_oh : '0;
    assign bus.rsp_data      = data_q;

    assign bus.ADC_C_Valid   = (state == CMD);
    assign bus.ADC_C_SOP     = (state == CMD);
    assign bus.ADC_C_EOP     = (state == CMD);
    assign bus.ADC_C_Channel = (state == CMD) ? chan_q : '0;

    assign busy      = (state != IDLE);
    assign owner     = owner_q;
    assign state_dbg = state;

    // Responses are always single-beat; the framing bits carry no information.
    assign unused_rsp_framing = bus.ADC_R_SOP ^ bus.ADC_R_EOP;

endmodule

// File: tb/tb_adc_cmd_arbiter.sv
module tb_adc_cmd_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic       CLK    = 1'b0;
    logic       RESETn = 1'b0;
    logic       busy;
    logic [2:0] owner;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model state: last accepted requester and per-requester channel.
    int         model_last = N_REQ - 1;
    logic [4:0] ch_arr [N_REQ];

    adc_cmd_arbiter_if #(.N_REQ(N_REQ)) bus ();

    adc_cmd_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .bus       (bus),
        .busy      (busy),
        .owner     (owner),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    // Round robin from the rules: search last+1, last+2, ... modulo N_REQ.
    function automatic int model_pick(input logic [N_REQ-1:0] pend, input int last);
        int idx;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (last + k) % N_REQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.req_valid     = '0;
        bus.req_channel   = '0;
        bus.ADC_C_Ready   = 1'b0;
        bus.ADC_R_Valid   = 1'b0;
        bus.ADC_R_SOP     = 1'b0;
        bus.ADC_R_EOP     = 1'b0;
        bus.ADC_R_Channel = '0;
        bus.ADC_R_Data    = '0;
    endtask

    task automatic apply_channels();
        for (int r = 0; r < N_REQ; r++) bus.req_channel[5*r +: 5] = ch_arr[r];
    endtask

    // Runs one conversion starting from an IDLE negedge with requests set.
    // The ADC answers on whatever channel the command carried.
    //   ready_delay : cycles ADC_C_Ready stays low while the command is shown
    //   stray_ch    : channel of an unrelated response in the first WAIT cycle (-1: none)
    //   rsp_at      : WAIT cycle index of the matching response (-1: never)
    // Returns what was observed; o_lat = WAIT cycles until a rsp strobe (-1: none).
    task automatic run_txn(input int ready_delay, input int stray_ch, input int rsp_at,
                           input logic [11:0] d_in,
                           output logic [N_REQ-1:0] o_ready, output logic [4:0] o_ch,
                           output bit o_cmd_ok, output logic [N_REQ-1:0] o_valid,
                           output logic [N_REQ-1:0] o_err, output logic [11:0] o_data,
                           output int o_lat);
        #1;
        o_ready  = bus.req_ready;
        o_valid  = '0;
        o_err    = '0;
        o_data   = '0;
        o_lat    = -1;
        o_cmd_ok = 1'b1;
        @(negedge CLK);
        bus.req_valid = bus.req_valid & ~o_ready;
        o_ch = bus.ADC_C_Channel;
        for (int i = 0; i <= ready_delay; i++) begin
            if (!(bus.ADC_C_Valid && bus.ADC_C_SOP && bus.ADC_C_EOP) || bus.ADC_C_Channel !== o_ch)
                o_cmd_ok = 1'b0;
            if (i == ready_delay) bus.ADC_C_Ready = 1'b1;
            @(negedge CLK);
        end
        bus.ADC_C_Ready = 1'b0;
        if (bus.ADC_C_Valid !== 1'b0) o_cmd_ok = 1'b0;
        for (int t = 0; t < TIMEOUT + 8; t++) begin
            if (bus.rsp_valid !== '0 || bus.rsp_err !== '0) begin
                o_valid = bus.rsp_valid;
                o_err   = bus.rsp_err;
                o_data  = bus.rsp_data;
                o_lat   = t;
                break;
            end
            bus.ADC_R_Valid   = 1'b0;
            bus.ADC_R_SOP     = 1'b0;
            bus.ADC_R_EOP     = 1'b0;
            bus.ADC_R_Channel = '0;
            bus.ADC_R_Data    = '0;
            if (t == 0 && stray_ch >= 0) begin
                bus.ADC_R_Valid   = 1'b1;
                bus.ADC_R_SOP     = 1'b1;
                bus.ADC_R_EOP     = 1'b1;
                bus.ADC_R_Channel = stray_ch[4:0];
                bus.ADC_R_Data    = ~d_in;
            end else if (t == rsp_at) begin
                bus.ADC_R_Valid   = 1'b1;
                bus.ADC_R_SOP     = 1'b1;
                bus.ADC_R_EOP     = 1'b1;
                bus.ADC_R_Channel = o_ch;
                bus.ADC_R_Data    = d_in;
            end
            @(negedge CLK);
        end
        bus.ADC_R_Valid   = 1'b0;
        bus.ADC_R_SOP     = 1'b0;
        bus.ADC_R_EOP     = 1'b0;
        bus.ADC_R_Channel = '0;
        bus.ADC_R_Data    = '0;
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESETn = 1'b0;
        drive_idle();
        bus.req_valid = '1;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (owner !== 3'd0) begin errors++; $display("FAIL rst_owner got=%0d exp=0", owner); end
        checks++; if (bus.rsp_data !== 12'h000) begin errors++; $display("FAIL rst_rsp_data got=%h exp=000", bus.rsp_data); end
        checks++; if (bus.ADC_C_Valid !== 1'b0 || bus.ADC_C_Channel !== 5'd0) begin errors++; $display("FAIL rst_adc_c got=%b/%0d exp=0/0", bus.ADC_C_Valid, bus.ADC_C_Channel); end
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_err !== 4'b0000) begin errors++; $display("FAIL rst_rsp got=%b/%b exp=0000/0000", bus.rsp_valid, bus.rsp_err); end
        bus.req_valid = '0;
        @(negedge CLK);
        RESETn = 1'b1;
        model_last = N_REQ - 1;
        @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_contention();
        logic [N_REQ-1:0] exp_q[$];
        logic [N_REQ-1:0] o_ready, o_valid, o_err, exp_oh;
        logic [4:0]       o_ch;
        logic [11:0]      o_data, d;
        bit               o_ok;
        int               o_lat, w;
        for (int i = 0; i < 8; i++) exp_q.push_back(4'b0001 << (i % 4));
        for (int r = 0; r < N_REQ; r++) ch_arr[r] = 5'(r + 10);
        apply_channels();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = '1;
            d = 12'($urandom);
            w = model_pick(4'b1111, model_last);
            exp_oh = exp_q.pop_front();
            run_txn(0, -1, int'($urandom_range(0, 3)), d, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
            model_last = w;
            checks++; if (o_ready !== exp_oh) begin errors++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, o_ready, exp_oh); end
            checks++; if (o_ch !== ch_arr[w]) begin errors++; $display("FAIL cont_chan[%0d] got=%0d exp=%0d", i, o_ch, ch_arr[w]); end
            checks++; if (o_valid !== exp_oh || o_data !== d) begin errors++; $display("FAIL cont_rsp[%0d] got=%b/%h exp=%b/%h", i, o_valid, o_data, exp_oh, d); end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[1] = 5'd5;
        apply_channels();
        bus.req_valid = 4'b0010;
        run_txn(0, -1, 0, 12'hABC, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 1;
        checks++; if (o_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", o_ready); end
        checks++; if (o_ch !== 5'd5 || !o_ok) begin errors++; $display("FAIL single_cmd got=ch%0d ok%0d exp=ch5 ok1", o_ch, o_ok); end
        checks++; if (o_valid !== 4'b0010 || o_err !== 4'b0000) begin errors++; $display("FAIL single_rsp got=%b/%b exp=0010/0000", o_valid, o_err); end
        checks++; if (o_data !== 12'hABC) begin errors++; $display("FAIL single_data got=%h exp=abc", o_data); end
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL single_latency got=%0d exp=1", o_lat); end
        checks++; if (busy !== 1'b0 || owner !== 3'd1 || bus.rsp_data !== 12'hABC) begin errors++; $display("FAIL single_after got=%b/%0d/%h exp=0/1/abc", busy, owner, bus.rsp_data); end
    endtask

    task automatic test_backpressure();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[0] = 5'd17;
        apply_channels();
        bus.req_valid = 4'b0001;
        run_txn(10, -1, 1, 12'h3C5, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 0;
        checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready got=%b exp=0001", o_ready); end
        checks++; if (!o_ok || o_ch !== 5'd17) begin errors++; $display("FAIL bp_cmd_stable got=ok%0d ch%0d exp=ok1 ch17", o_ok, o_ch); end
        checks++; if (o_valid !== 4'b0001 || o_data !== 12'h3C5) begin errors++; $display("FAIL bp_rsp got=%b/%h exp=0001/3c5", o_valid, o_data); end
    endtask

    task automatic test_stray();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[2] = 5'd3;
        apply_channels();
        bus.req_valid = 4'b0100;
        run_txn(0, 7, 2, 12'h123, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 2;
        checks++; if (o_ch !== 5'd3) begin errors++; $display("FAIL stray_chan got=%0d exp=3", o_ch); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL stray_latency got=%0d exp=3", o_lat); end
        checks++; if (o_valid !== 4'b0100 || o_data !== 12'h123) begin errors++; $display("FAIL stray_rsp got=%b/%h exp=0100/123", o_valid, o_data); end
    endtask

    task automatic test_timeout();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[3] = 5'd4;
        apply_channels();
        bus.req_valid = 4'b1000;
        run_txn(1, -1, -1, 12'h000, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 3;
        checks++; if (o_err !== 4'b1000 || o_valid !== 4'b0000) begin errors++; $display("FAIL to_strobe got=%b/%b exp=1000/0000", o_err, o_valid); end
        checks++; if (o_lat !== TIMEOUT) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", o_lat, TIMEOUT); end
        checks++; if (busy !== 1'b0 || bus.rsp_data !== 12'h000) begin errors++; $display("FAIL to_after got=%b/%h exp=0/000", busy, bus.rsp_data); end
        ch_arr[1] = 5'd6;
        apply_channels();
        bus.req_valid = 4'b0010;
        run_txn(0, -1, 0, 12'h5A5, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 1;
        checks++; if (o_ready !== 4'b0010 || o_valid !== 4'b0010 || o_data !== 12'h5A5) begin errors++; $display("FAIL to_next got=%b/%b/%h exp=0010/0010/5a5", o_ready, o_valid, o_data); end
    endtask

    task automatic test_boundary();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[2] = 5'd31;
        apply_channels();
        bus.req_valid = 4'b0100;
        run_txn(0, -1, TIMEOUT - 1, 12'hFED, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 2;
        checks++; if (o_valid !== 4'b0100 || o_err !== 4'b0000) begin errors++; $display("FAIL edge_rsp got=%b/%b exp=0100/0000", o_valid, o_err); end
        checks++; if (o_data !== 12'hFED || o_lat !== TIMEOUT) begin errors++; $display("FAIL edge_data got=%h/%0d exp=fed/%0d", o_data, o_lat, TIMEOUT); end
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] o_ready, o_valid, o_err, mask, exp_oh;
        logic [4:0]       o_ch, stray;
        logic [11:0]      o_data, d, exp_d;
        bit               o_ok, to;
        int               o_lat, w, rsp_at, bp, st, exp_lat;
        for (int it = 0; it < 14; it++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int r = 0; r < N_REQ; r++)
                if (mask[r] && !bus.req_valid[r]) ch_arr[r] = 5'($urandom_range(0, 31));
            mask = mask | bus.req_valid;
            apply_channels();
            bus.req_valid = mask;
            w      = model_pick(mask, model_last);
            exp_oh = 4'b0001 << w;
            to     = ($urandom_range(0, 4) == 0);
            stray  = ch_arr[w] + 5'($urandom_range(1, 31));
            st     = ($urandom_range(0, 1) == 1) ? int'(stray) : -1;
            rsp_at = to ? -1 : int'($urandom_range((st >= 0) ? 1 : 0, TIMEOUT - 2));
            bp     = int'($urandom_range(0, 4));
            d      = 12'($urandom);
            exp_d  = to ? 12'h000 : d;
            exp_lat = to ? TIMEOUT : rsp_at + 1;
            run_txn(bp, st, rsp_at, d, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
            model_last = w;
            checks++; if (o_ready !== exp_oh) begin errors++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", it, o_ready, exp_oh); end
            checks++; if (o_ch !== ch_arr[w] || !o_ok) begin errors++; $display("FAIL rnd_cmd[%0d] got=ch%0d ok%0d exp=ch%0d ok1", it, o_ch, o_ok, ch_arr[w]); end
            checks++; if (o_valid !== (to ? 4'b0000 : exp_oh) || o_err !== (to ? exp_oh : 4'b0000)) begin errors++; $display("FAIL rnd_strobe[%0d] got=%b/%b exp_to=%0d owner=%0d", it, o_valid, o_err, to, w); end
            checks++; if (o_data !== exp_d || o_lat !== exp_lat) begin errors++; $display("FAIL rnd_data[%0d] got=%h/%0d exp=%h/%0d", it, o_data, o_lat, exp_d, exp_lat); end
            checks++; if (bus.rsp_data !== exp_d || busy !== 1'b0) begin errors++; $display("FAIL rnd_hold[%0d] got=%h/%b exp=%h/0", it, bus.rsp_data, busy, exp_d); end
        end
        bus.req_valid = '0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_wait();
        logic [N_REQ-1:0] o_ready, o_valid, o_err;
        logic [4:0]       o_ch;
        logic [11:0]      o_data;
        bit               o_ok;
        int               o_lat;
        ch_arr[3] = 5'd9;
        apply_channels();
        bus.req_valid = 4'b1000;
        @(negedge CLK);
        bus.req_valid   = '0;
        bus.ADC_C_Ready = 1'b1;
        @(negedge CLK);
        bus.ADC_C_Ready = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (busy !== 1'b1 || owner !== 3'd3) begin errors++; $display("FAIL mid_wait_busy got=%b/%0d exp=1/3", busy, owner); end
        RESETn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || owner !== 3'd0 || bus.rsp_data !== 12'h000) begin errors++; $display("FAIL mid_rst_state got=%b/%0d/%h exp=0/0/000", busy, owner, bus.rsp_data); end
        checks++; if (bus.ADC_C_Valid !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.rsp_err !== '0) begin errors++; $display("FAIL mid_rst_strobes got=%b/%b/%b/%b exp=0", bus.ADC_C_Valid, bus.req_ready, bus.rsp_valid, bus.rsp_err); end
        @(negedge CLK);
        RESETn = 1'b1;
        model_last = N_REQ - 1;
        @(negedge CLK);
        for (int r = 0; r < N_REQ; r++) ch_arr[r] = 5'(20 + r);
        apply_channels();
        bus.req_valid = '1;
        run_txn(0, -1, 2, 12'h777, o_ready, o_ch, o_ok, o_valid, o_err, o_data, o_lat);
        model_last = 0;
        bus.req_valid = '0;
        checks++; if (o_ready !== 4'b0001 || o_ch !== 5'd20) begin errors++; $display("FAIL mid_rst_first_grant got=%b/%0d exp=0001/20", o_ready, o_ch); end
        checks++; if (o_valid !== 4'b0001 || o_data !== 12'h777) begin errors++; $display("FAIL mid_rst_rsp got=%b/%h exp=0001/777", o_valid, o_data); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        for (int r = 0; r < N_REQ; r++) ch_arr[r] = '0;
        drive_idle();
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_stray();
        test_timeout();
        test_boundary();
        test_random();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_cmd_arbiter.md
ADC_CMD_ARBITER -- requirements
Module: adc_cmd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum CLK cycles to wait for a response (>=2).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port RESETn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester conversion request.
REQ-006 SHALL have port req_channel  input  5*N_REQ  requested ADC channel; requester i uses bits [5i+4:5i].
REQ-007 SHALL have port req_ready  output  N_REQ  one-cycle accept strobe to the granted requester.
REQ-008 SHALL have port rsp_valid  output  N_REQ  one-cycle result strobe to the owner.
REQ-009 SHALL have port rsp_err  output  N_REQ  one-cycle timeout strobe to the owner.
REQ-010 SHALL have port rsp_data  output  12  conversion result, qualified by rsp_valid.
REQ-011 SHALL have ports ADC_C_Valid, ADC_C_SOP, ADC_C_EOP  output  1 each;  ADC_C_Channel  output  5;  ADC_C_Ready  input  1  (ADC command stream).
REQ-012 SHALL have ports ADC_R_Valid, ADC_R_SOP, ADC_R_EOP  input  1 each;  ADC_R_Channel  input  5;  ADC_R_Data  input  12  (ADC response stream).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port owner  output  3  index of the current or last granted requester.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, WAIT, RESP with only one conversion outstanding at any time.
REQ-016 In IDLE with any req_valid set, SHALL select a winner round-robin, starting the search at last_grant+1 modulo N_REQ.
REQ-017 SHALL assert req_ready[winner] for exactly the IDLE cycle of selection (combinational from state and req_valid), latch winner into owner and its channel, then enter CMD.
REQ-018 In CMD, SHALL drive ADC_C_Valid=1, ADC_C_SOP=1, ADC_C_EOP=1, ADC_C_Channel=latched channel, holding all stable until ADC_C_Ready=1; that cycle it SHALL enter WAIT.
REQ-019 ADC_C_Valid, SOP and EOP SHALL be 0 in every state other than CMD.
REQ-020 In WAIT, a cycle with ADC_R_Valid=1 and ADC_R_Channel equal to the latched channel SHALL capture ADC_R_Data and enter RESP; a response on any other channel SHALL be ignored.
REQ-021 In RESP, SHALL assert rsp_valid[owner]=1 with rsp_data=captured value for one cycle, then return to IDLE.
REQ-022 SHALL count WAIT cycles from 0; if the count reaches TIMEOUT-1 without a matching response, SHALL pulse rsp_err[owner] for one cycle on the next cycle, force rsp_data=0, and return to IDLE.
REQ-023 A matching response arriving in the same cycle the timeout count is reached SHALL win; no error is raised.
REQ-024 SHALL update last_grant to the winner only upon acceptance; requests not granted remain pending without loss while req_valid stays high.
REQ-025 Minimum latency: acceptance at cycle 0, ADC_C_Valid at cycle 1, rsp_valid one cycle after the matching ADC_R_Valid.
REQ-026 SHALL keep rsp_data stable after RESP until the next RESP or timeout.
REQ-027 SHALL never assert more than one bit of req_ready, rsp_valid or rsp_err in the same cycle.

Reset
REQ-028 On RESETn=0, at any time including mid-transaction, SHALL asynchronously set state=IDLE, last_grant=N_REQ-1, owner=0, rsp_data=0, counter=0, and drive every output strobe and ADC_C_* to 0.
REQ-029 After reset release, requester 0 SHALL have highest priority for the first grant.

Verification
REQ-030 Single request: req_valid[1]=1, channel 5, ADC answers channel 5 with data 0xABC -> one ADC command with channel 5, SOP=EOP=1; rsp_valid[1]=1, rsp_data=0xABC.
REQ-031 Contention: all 4 requesters held valid for 8 conversions -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Backpressure: ADC_C_Ready held low 10 cycles -> ADC_C_Valid and ADC_C_Channel stable for all 10 cycles; one command transferred.
REQ-033 Stray response: channel 7 response while waiting on channel 3, then channel 3 response with 0x123 -> first response ignored, rsp_data=0x123.
REQ-034 Timeout: TIMEOUT=16, no response -> rsp_err[owner] pulses 16 cycles after entering WAIT; busy falls; next request is accepted normally.
REQ-035 Reset mid-WAIT: RESETn low for 1 cycle -> all outputs 0 immediately; next grant goes to requester 0.
